dm_cache_line_fill_axi: RTL

//  AXI4 read-burst line-fill engine between the direct-mapped cache controller and the AXI memory slave.
//  On a cache miss the controller hands over the miss address.
//  The block issues one INCR burst for the whole line and streams each beat back with its word index.
//  At the end it signals done, or done with an error.

---
 rtl/dm_cache_line_fill_axi.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dm_cache_line_fill_axi.sv
// dm_cache_line_fill_axi
// AXI4 read-burst line-fill engine sitting between the direct-mapped cache
// controller and an AXI memory slave. A miss address is turned into a single
// line-aligned INCR burst; every returned beat is forwarded to the cache with
// its word index, and the fill ends with a done pulse that carries a sticky
// error flag (bad RRESP or RLAST in the wrong place).

module dm_cache_line_fill_axi #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int AXI_ID     = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,

    // Cache controller side
    input  logic                          fill_req,
    input  logic [ADDR_WIDTH-1:0]         fill_addr,
    output logic                          fill_ready,
    output logic                          fill_word_valid,
    output logic [$clog2(LINE_WORDS)-1:0] fill_word_idx,
    output logic [DATA_WIDTH-1:0]         fill_word_data,
    output logic                          fill_done,
    output logic                          fill_err,

    // AXI4 read address channel
    output logic [3:0]                    m_axi_arid,
    output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,

    // AXI4 read data channel
    input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int IDX_W      = $clog2(LINE_WORDS);
    localparam int LINE_BYTES = LINE_WORDS * DATA_WIDTH / 8;
    localparam int OFF_W      = $clog2(LINE_BYTES);

    // Clears the byte-offset-within-line bits so the burst starts on the line
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] beat_cnt;
    logic             err_sticky;

    logic             beat_hs;
    logic             beat_is_last;
    logic             beat_bad;

    // The burst shape never changes: whole line, one word per beat, INCR
    assign m_axi_arid    = 4'(AXI_ID);
    assign m_axi_arlen   = 8'(LINE_WORDS - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;

    // Per-beat decode: the beat counter decides which beat is last, RLAST must agree with it
    always_comb begin
        beat_hs      = m_axi_rvalid && m_axi_rready;
        beat_is_last = (beat_cnt == LAST_BEAT);
        beat_bad     = (m_axi_rresp != 2'b00) || (m_axi_rlast != beat_is_last);
    end

    // Fill sequencer: accept a miss, issue the AR request, stream the beats, then report done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            fill_ready      <= 1'b1;
            fill_word_valid <= 1'b0;
            fill_word_idx   <= '0;
            fill_word_data  <= '0;
            fill_done       <= 1'b0;
            fill_err        <= 1'b0;
            m_axi_araddr    <= '0;
            m_axi_arvalid   <= 1'b0;
            m_axi_rready    <= 1'b0;
            beat_cnt        <= '0;
            err_sticky      <= 1'b0;
        end else begin
            fill_word_valid <= 1'b0;
            fill_done       <= 1'b0;
            fill_err        <= 1'b0;

            case (state)
                IDLE: begin
                    if (fill_req && fill_ready) begin
                        state         <= ADDR;
                        fill_ready    <= 1'b0;
                        m_axi_araddr  <= fill_addr & LINE_MASK;
                        m_axi_arvalid <= 1'b1;
                        beat_cnt      <= '0;
                        err_sticky    <= 1'b0;
                    end
                end

                ADDR: begin
                    if (m_axi_arvalid && m_axi_arready) begin
                        state         <= DATA;
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                    end
                end

                DATA: begin
                    if (beat_hs) begin
                        fill_word_valid <= 1'b1;
                        fill_word_idx   <= beat_cnt;
                        fill_word_data  <= m_axi_rdata;
                        beat_cnt        <= beat_cnt + 1'b1;
                        err_sticky      <= err_sticky | beat_bad;
                        if (beat_is_last) begin
                            state        <= DONE;
                            m_axi_rready <= 1'b0;
                            fill_done    <= 1'b1;
                            fill_err     <= err_sticky | beat_bad;
                        end
                    end
                end

                DONE: begin
                    state      <= IDLE;
                    fill_ready <= 1'b1;
                end

                default: begin
                    state         <= IDLE;
                    fill_ready    <= 1'b1;
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b0;
                end
            endcase
        end
    end

endmodule
